vending_core_param: RTL and testbench

Parametrised transaction engine for the vending machine: it holds per-item stock and price for `NUM_ITEMS` slots and executes buy, restock and query commands one at a time. Commands arrive over a valid/ready handshake, and results leave over a second one. It replaces the fixed 8-item, 7-bit datapath inside `Main`, and sits between the front-panel input logic and the 7-segment display drivers. Change computation, error reporting and an optional revenue audit are built in.

---
 rtl/vending_core_param.sv | 207 ++++++++++++++++++++
 tb/tb_vending_core_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_core_param.sv
// vending_core_param: parametrised buy/restock/query engine for the vending machine.
// Commands are taken over a valid/ready handshake and run one at a time through
// IDLE -> LOAD -> EVAL -> COMMIT -> RESP. Results leave over a second handshake.
// Optional revenue audit: define VEND_AUDIT_EN to build the accumulator;
// otherwise rsp_revenue is tied to 0.
module vending_core_param #(
    parameter int ITEM_W        = 3,
    parameter int STOCK_W       = 4,
    parameter int MONEY_W       = 7,
    parameter int REV_W         = 16,
    parameter int DEFAULT_PRICE = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [ITEM_W-1:0]  cmd_item,
    input  logic [STOCK_W-1:0] cmd_qty,
    input  logic [MONEY_W-1:0] cmd_money,
    input  logic [MONEY_W-1:0] cmd_price,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_error,
    output logic [MONEY_W-1:0] rsp_change,
    output logic [STOCK_W-1:0] rsp_stock,
    output logic [REV_W-1:0]   rsp_revenue
);
    localparam int NUM_ITEMS = 2**ITEM_W;
    localparam int COST_W    = MONEY_W + STOCK_W;
    localparam logic [STOCK_W-1:0] MAX_STOCK = '1;

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, COMMIT, RESP} state_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [ITEM_W-1:0]  item;
        logic [STOCK_W-1:0] qty;
        logic [MONEY_W-1:0] money;
        logic [MONEY_W-1:0] price;
    } cmd_t;

    state_t state;
    cmd_t   cmd_r;

    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_mem;
    logic [NUM_ITEMS-1:0][MONEY_W-1:0] price_mem;

    // item state snapshot taken in LOAD
    logic [STOCK_W-1:0] l_stock;
    logic [MONEY_W-1:0] l_price;

    // EVAL results, consumed in COMMIT
    logic [2:0]         e_err;
    logic [STOCK_W-1:0] e_stock;
    logic [MONEY_W-1:0] e_price;
    logic [MONEY_W-1:0] e_change;

    // combinational evaluation of the loaded command
    logic [COST_W-1:0]  cost;
    logic [STOCK_W:0]   stock_sum;
    logic [2:0]         n_err;
    logic [STOCK_W-1:0] n_stock;
    logic [MONEY_W-1:0] n_price;
    logic [MONEY_W-1:0] n_change;
    logic [COST_W-1:0]  n_add;

    assign cmd_ready = (state == IDLE);

    // decide error and next item state; cost is full width so no product is lost
    always_comb begin
        cost      = COST_W'(l_price) * COST_W'(cmd_r.qty);
        stock_sum = {1'b0, l_stock} + {1'b0, cmd_r.qty};
        n_err     = 3'd0;
        n_stock   = l_stock;
        n_price   = l_price;
        n_change  = l_price;
        n_add     = '0;
        case (cmd_r.mode)
            2'd0: begin
                n_err    = 3'd1;
                n_change = cmd_r.money;
            end
            2'd1: begin
                n_change = cmd_r.money;
                if (cmd_r.qty == '0)
                    n_err = 3'd5;
                else if (cmd_r.qty > l_stock)
                    n_err = 3'd2;
                else if (cost > COST_W'(cmd_r.money))
                    n_err = 3'd3;
                else begin
                    n_stock  = l_stock - cmd_r.qty;
                    // cost <= money here, so the difference fits MONEY_W
                    n_change = cmd_r.money - cost[MONEY_W-1:0];
                    n_add    = cost;
                end
            end
            2'd2: begin
                if (cmd_r.qty == '0)
                    n_err = 3'd5;
                else if (stock_sum > {1'b0, MAX_STOCK})
                    n_err = 3'd4;
                else begin
                    n_stock = stock_sum[STOCK_W-1:0];
                    if (cmd_r.price != '0) begin
                        n_price  = cmd_r.price;
                        n_change = cmd_r.price;
                    end
                end
            end
            default: ;
        endcase
    end

    // transaction FSM with item memories and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_r      <= '0;
            l_stock    <= '0;
            l_price    <= '0;
            e_err      <= '0;
            e_stock    <= '0;
            e_price    <= '0;
            e_change   <= '0;
            rsp_valid  <= 1'b0;
            rsp_error  <= '0;
            rsp_change <= '0;
            rsp_stock  <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_mem[i] <= '0;
                price_mem[i] <= MONEY_W'(DEFAULT_PRICE);
            end
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_r <= '{cmd_mode, cmd_item, cmd_qty, cmd_money, cmd_price};
                    state <= LOAD;
                end
                LOAD: begin
                    l_stock <= stock_mem[cmd_r.item];
                    l_price <= price_mem[cmd_r.item];
                    state   <= EVAL;
                end
                EVAL: begin
                    e_err    <= n_err;
                    e_stock  <= n_stock;
                    e_price  <= n_price;
                    e_change <= n_change;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    stock_mem[cmd_r.item] <= e_stock;
                    price_mem[cmd_r.item] <= e_price;
                    rsp_error  <= e_err;
                    rsp_change <= e_change;
                    rsp_stock  <= e_stock;
                    state      <= RESP;
                end
                RESP: begin
                    // valid rises one cycle after the response data settles
                    if (!rsp_valid)
                        rsp_valid <= 1'b1;
                    else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VEND_AUDIT_EN
    logic [COST_W-1:0] e_add;
    logic [REV_W-1:0]  revenue;
    logic [REV_W-1:0]  rev_q;
    logic [REV_W:0]    rev_sum;
    logic [REV_W-1:0]  rev_next;

    assign rev_sum     = {1'b0, revenue} + (REV_W+1)'(e_add);
    assign rev_next    = rev_sum[REV_W] ? '1 : rev_sum[REV_W-1:0];
    assign rsp_revenue = rev_q;

    // saturating revenue accumulator, updated with the commit
    always_ff @(posedge clk) begin
        if (reset) begin
            e_add   <= '0;
            revenue <= '0;
            rev_q   <= '0;
        end else begin
            if (state == EVAL)
                e_add <= n_add;
            if (state == COMMIT) begin
                revenue <= rev_next;
                rev_q   <= rev_next;
            end
        end
    end
`else
    logic unused_add;
    assign unused_add  = ^n_add;
    assign rsp_revenue = '0;
`endif

endmodule

// File: tb/tb_vending_core_param.sv
// Scoreboard bench for vending_core_param: a reference model pushes the expected
// response when each command is driven; it is popped and compared on rsp_valid.
module tb_vending_core_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_item;
    logic [3:0] cmd_qty;
    logic [6:0] cmd_money;
    logic [6:0] cmd_price;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_error;
    logic [6:0] rsp_change;
    logic [3:0] rsp_stock;
    logic [15:0] rsp_revenue;

    typedef struct {
        logic [2:0]  err;
        logic [6:0]  change;
        logic [3:0]  stock;
        logic [15:0] rev;
    } exp_t;

    exp_t sb[$];
    int   m_stock[8];
    int   m_price[8];
    int   m_rev;
    int   n_chk  = 0;
    int   n_fail = 0;

    vending_core_param dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_item(cmd_item), .cmd_qty(cmd_qty),
        .cmd_money(cmd_money), .cmd_price(cmd_price),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_error(rsp_error), .rsp_change(rsp_change),
        .rsp_stock(rsp_stock), .rsp_revenue(rsp_revenue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_stock[i] = 0;
            m_price[i] = 10;
        end
        m_rev = 0;
    endtask

    // reference behaviour; pushes the expected response
    task automatic model(input logic [1:0] mode, input logic [2:0] item, input logic [3:0] qty,
                         input logic [6:0] money, input logic [6:0] price);
        exp_t e;
        int   cost;
        int   st;
        st   = m_stock[item];
        cost = m_price[item] * int'(qty);
        e.err = 3'd0;
        case (mode)
            2'd0: e.err = 3'd1;
            2'd1: begin
                if (qty == 0)                e.err = 3'd5;
                else if (int'(qty) > st)     e.err = 3'd2;
                else if (cost > int'(money)) e.err = 3'd3;
                else begin
                    m_stock[item] = st - int'(qty);
                    m_rev = (m_rev + cost > 65535) ? 65535 : m_rev + cost;
                end
            end
            2'd2: begin
                if (qty == 0)               e.err = 3'd5;
                else if (st + int'(qty) > 15) e.err = 3'd4;
                else begin
                    m_stock[item] = st + int'(qty);
                    if (price != 0) m_price[item] = int'(price);
                end
            end
            default: ;
        endcase
        if (mode == 2'd0 || mode == 2'd1)
            e.change = (mode == 2'd1 && e.err == 0) ? 7'(int'(money) - cost) : money;
        else
            e.change = 7'(m_price[item]);
        e.stock = 4'(m_stock[item]);
`ifdef VEND_AUDIT_EN
        e.rev = 16'(m_rev);
`else
        e.rev = 16'd0;
`endif
        sb.push_back(e);
    endtask

    // drive one command, hold rsp_ready low for 'stall' extra cycles, then handshake
    task automatic run_cmd(input logic [1:0] mode, input logic [2:0] item, input logic [3:0] qty,
                           input logic [6:0] money, input logic [6:0] price, input int stall);
        exp_t e;
        int   n;
        model(mode, item, qty, money, price);
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_item  = item;
        cmd_qty   = qty;
        cmd_money = money;
        cmd_price = price;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
        cmd_item  = 3'($urandom);
        cmd_qty   = 4'($urandom);
        cmd_money = 7'($urandom);
        cmd_price = 7'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid && n < 20);
        check("latency", 32'(n), 32'd4);
        e = sb.pop_front();
        for (int k = 0; k <= stall; k++) begin
            check("rsp_error",   32'(rsp_error),   32'(e.err));
            check("rsp_change",  32'(rsp_change),  32'(e.change));
            check("rsp_stock",   32'(rsp_stock),   32'(e.stock));
            check("rsp_revenue", 32'(rsp_revenue), 32'(e.rev));
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (k < stall) begin
                cmd_valid = 1'b1;
                cmd_mode  = 2'($urandom);
                cmd_item  = 3'($urandom);
                cmd_qty   = 4'($urandom);
                @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_item = '0; cmd_qty = '0;
        cmd_money = '0; cmd_price = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst_rsp_error",   32'(rsp_error),   32'd0);
        check("rst_rsp_change",  32'(rsp_change),  32'd0);
        check("rst_rsp_stock",   32'(rsp_stock),   32'd0);
        check("rst_rsp_revenue", 32'(rsp_revenue), 32'd0);
        reset = 1'b0;

        run_cmd(2'd3, 3'd3, 4'd0, 7'd0,  7'd0,  0);   // query after reset
        run_cmd(2'd2, 3'd0, 4'd5, 7'd0,  7'd0,  0);   // restock 5
        run_cmd(2'd1, 3'd0, 4'd1, 7'd20, 7'd0,  0);   // buy ok, change 10
        run_cmd(2'd1, 3'd0, 4'd3, 7'd29, 7'd0,  0);   // short on money
        run_cmd(2'd1, 3'd7, 4'd3, 7'd50, 7'd0,  0);   // short on stock
        run_cmd(2'd1, 3'd0, 4'd0, 7'd50, 7'd0,  0);   // zero qty
        run_cmd(2'd0, 3'd0, 4'd1, 7'd33, 7'd0,  0);   // bad mode
        run_cmd(2'd2, 3'd1, 4'd15, 7'd0, 7'd12, 0);   // fill to max, new price
        run_cmd(2'd2, 3'd1, 4'd1, 7'd0,  7'd0,  0);   // overflow
        run_cmd(2'd3, 3'd1, 4'd0, 7'd0,  7'd0,  10);  // query with 10-cycle stall

        for (int i = 0; i < 40; i++)
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
                    7'($urandom_range(0, 20)), int'($urandom_range(0, 2)));

        // reset while a buy sits in EVAL
        run_cmd(2'd2, 3'd2, 4'd3, 7'd0, 7'd0, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_item = 3'd2; cmd_qty = 4'd1;
        cmd_money = 7'd50; cmd_price = 7'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("abort_cmd_ready", 32'(cmd_ready),   32'd1);
        check("abort_rsp_valid", 32'(rsp_valid),   32'd0);
        check("abort_revenue",   32'(rsp_revenue), 32'd0);
        for (int i = 0; i < 8; i++)
            run_cmd(2'd3, 3'(i), 4'd0, 7'd0, 7'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
